// File: rtl/banco_registros_param_if.sv
// banco_registros_param_if: write/read bus of the register file.
// master drives addresses and write data; slave returns read data.
interface banco_registros_param_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              regWrite;
  logic [ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0] writeData;
  logic [ADDR_W-1:0] read1;
  logic [ADDR_W-1:0] read2;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic              ready;
  logic              wr_dropped;

  modport master (
    output regWrite, writeReg, writeData,
    output read1, read2,
    input  data1, data2, ready, wr_dropped
  );

  modport slave (
    input  regWrite, writeReg, writeData,
    input  read1, read2,
    output data1, data2, ready, wr_dropped
  );
endinterface

// File: rtl/banco_registros_param.sv
// banco_registros_param: parametrised 2R/1W register file with
// post-reset clear sweep, optional zero register and write bypass.
module banco_registros_param #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic clk,
  input logic rst,
  banco_registros_param_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              drop_q, drop_d;
  logic              wr_ok;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] ra [2];
  logic [DATA_W-1:0] rd [2];

  assign ra[0] = bus.read1;
  assign ra[1] = bus.read2;

  // A write lands only in RUN, in range, and not on a hardwired r0.
  assign wr_ok = (state_q == RUN) && bus.regWrite &&
                 (bus.writeReg <= LAST) &&
                 !(ZERO_REG && bus.writeReg == '0);

  // State, sweep index and drop flag; async clear on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CLEAR;
      idx_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
    end
  end

  // Sweep through every entry once, then stay in RUN.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    drop_d  = bus.regWrite && !wr_ok;
    unique case (state_q)
      CLEAR: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          state_d = RUN;
          idx_d   = '0;
        end
      end
      RUN: state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  // Status outputs.
  always_comb begin
    bus.ready      = (state_q == RUN);
    bus.wr_dropped = drop_q;
  end

  // Storage: zeroed by the sweep, written in RUN; no reset.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR)
      mem[idx_q] <= '0;
    else if (wr_ok)
      mem[bus.writeReg] <= bus.writeData;
  end

  // Read ports: masked to 0, then bypass after the storage mux.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd[p] = '0;
      if ((state_q == RUN) && (ra[p] <= LAST) &&
          !(ZERO_REG && ra[p] == '0)) begin
        if (BYPASS && wr_ok && bus.writeReg == ra[p])
          rd[p] = bus.writeData;
        else
          rd[p] = mem[ra[p]];
      end
    end
  end

  assign bus.data1 = rd[0];
  assign bus.data2 = rd[1];

endmodule

// File: tb/tb_banco_registros_param.sv
// tb_banco_registros_param: directed checks of two file configs
// driven by the same bus stimulus.
module tb_banco_registros_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we  = 1'b0;
  logic [4:0]  wa  = '0;
  logic [31:0] wd  = '0;
  logic [4:0]  r1  = '0;
  logic [4:0]  r2  = '0;

  int n_run  = 0;
  int n_fail = 0;
  logic [31:0] mb [24];

  always #5 clk = ~clk;

  banco_registros_param_if #(.ADDR_W(5), .DATA_W(32)) ifa ();
  banco_registros_param_if #(.ADDR_W(5), .DATA_W(32)) ifb ();

  assign ifa.regWrite  = we;
  assign ifa.writeReg  = wa;
  assign ifa.writeData = wd;
  assign ifa.read1     = r1;
  assign ifa.read2     = r2;
  assign ifb.regWrite  = we;
  assign ifb.writeReg  = wa;
  assign ifb.writeData = wd;
  assign ifb.read1     = r1;
  assign ifb.read2     = r2;

  banco_registros_param #(
    .DATA_W(32), .DEPTH(32), .ADDR_W(5),
    .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave)
  );

  banco_registros_param #(
    .DATA_W(32), .DEPTH(24), .ADDR_W(5),
    .ZERO_REG(1'b0), .BYPASS(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a,
                    input logic [31:0] d);
    we = 1'b1; wa = a; wd = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 24; i++) mb[i] = '0;

    repeat (3) tick();
    chk("rst_rdy_a", 32'(ifa.ready), 0);
    chk("rst_rdy_b", 32'(ifb.ready), 0);
    chk("rst_drp_a", 32'(ifa.wr_dropped), 0);
    chk("rst_d1_a", ifa.data1, 0);
    rst = 1'b1;

    // Sweep: e edges done before each check.
    for (int e = 0; e < 32; e++) begin
      r1 = 5'(e);
      r2 = 5'(31 - e);
      we = (e == 2);
      wa = 5'd4;
      wd = 32'd1;
      #3;
      chk("swp_rdy_a", 32'(ifa.ready), 0);
      chk("swp_rdy_b", 32'(ifb.ready), 32'(e >= 24));
      chk("swp_d1_a", ifa.data1, 0);
      chk("swp_d2_a", ifa.data2, 0);
      tick();
      chk("swp_drp_a", 32'(ifa.wr_dropped), 32'(e == 2));
      chk("swp_drp_b", 32'(ifb.wr_dropped), 32'(e == 2));
    end
    we = 1'b0;
    chk("rdy_a", 32'(ifa.ready), 1);
    chk("rdy_b", 32'(ifb.ready), 1);

    for (int a = 0; a < 32; a++) begin
      r1 = 5'(a);
      r2 = 5'(a);
      #1;
      chk("clr_d1_a", ifa.data1, 0);
      chk("clr_d2_a", ifa.data2, 0);
      chk("clr_d1_b", ifb.data1, 0);
    end

    // Write 5 <- 7, read on both ports.
    r1 = 5'd5; r2 = 5'd5;
    we = 1'b1; wa = 5'd5; wd = 32'd7;
    #3;
    chk("byp_d1_a", ifa.data1, 7);
    chk("byp_d2_a", ifa.data2, 7);
    chk("nbyp_d1_b", ifb.data1, 0);
    chk("nbyp_d2_b", ifb.data2, 0);
    tick();
    we = 1'b0;
    mb[5] = 32'd7;
    #1;
    chk("wr_d1_a", ifa.data1, 7);
    chk("wr_d2_a", ifa.data2, 7);
    chk("wr_d1_b", ifb.data1, 7);
    chk("wr_d2_b", ifb.data2, 7);
    chk("wr_drp_a", 32'(ifa.wr_dropped), 0);

    // Register 0: hardwired in A, ordinary in B.
    r1 = 5'd0;
    we = 1'b1; wa = 5'd0; wd = 32'hDEADBEEF;
    #3;
    chk("z0_now_a", ifa.data1, 0);
    chk("z0_now_b", ifb.data1, 0);
    tick();
    we = 1'b0;
    mb[0] = 32'hDEADBEEF;
    chk("z0_drp_a", 32'(ifa.wr_dropped), 1);
    chk("z0_drp_b", 32'(ifb.wr_dropped), 0);
    chk("z0_later_a", ifa.data1, 0);
    chk("z0_later_b", ifb.data1, 32'hDEADBEEF);
    tick();
    chk("z0_pulse_a", 32'(ifa.wr_dropped), 0);

    // Address 30: in range for A, out of range for B.
    r1 = 5'd30;
    we = 1'b1; wa = 5'd30; wd = 32'h1234;
    #3;
    chk("oor_byp_a", ifa.data1, 32'h1234);
    chk("oor_now_b", ifb.data1, 0);
    tick();
    we = 1'b0;
    chk("oor_drp_b", 32'(ifb.wr_dropped), 1);
    chk("oor_drp_a", 32'(ifa.wr_dropped), 0);
    chk("oor_d1_b", ifb.data1, 0);
    chk("oor_d1_a", ifa.data1, 32'h1234);
    tick();
    chk("oor_pulse_b", 32'(ifb.wr_dropped), 0);
    for (int a = 0; a < 24; a++) begin
      r2 = 5'(a);
      #1;
      chk("oor_keep_b", ifb.data2, mb[a]);
    end

    // Back-to-back writes, last one wins.
    r1 = 5'd9;
    wr(5'd9, 32'h11);
    wr(5'd9, 32'h22);
    chk("b2b_a", ifa.data1, 32'h22);
    chk("b2b_b", ifb.data1, 32'h22);

    // Fill 1..5, then an asynchronous reset pulse.
    wr(5'd1, 32'd4);
    wr(5'd2, 32'd9);
    wr(5'd3, 32'd1);
    wr(5'd4, 32'd1);
    wr(5'd5, 32'd7);
    r1 = 5'd2; r2 = 5'd5;
    #1;
    chk("fill_d1_a", ifa.data1, 9);
    chk("fill_d2_b", ifb.data2, 7);
    rst = 1'b0;
    #1;
    chk("mid_rdy_a", 32'(ifa.ready), 0);
    chk("mid_rdy_b", 32'(ifb.ready), 0);
    chk("mid_d1_a", ifa.data1, 0);
    #4;
    rst = 1'b1;
    for (int e = 0; e < 32; e++) begin
      #1;
      chk("re_rdy_a", 32'(ifa.ready), 0);
      tick();
    end
    chk("re_rdy_a_end", 32'(ifa.ready), 1);
    for (int a = 0; a < 32; a++) begin
      r1 = 5'(a);
      r2 = 5'(a);
      #1;
      chk("re_clr_a", ifa.data1, 0);
      chk("re_clr_b", ifb.data2, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
